// File: rtl/noc_client_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : noc_client_pkg
//  Description : Shared constants for the NoC traffic client: traffic-pattern
//                encodings, payload field offsets and the LFSR tap mask.
//  Revision    : 1.0 - initial release
// ============================================================================
package noc_client_pkg;

    // Traffic pattern selectors
    localparam int PAT_UNIFORM   = 0;
    localparam int PAT_TRANSPOSE = 1;
    localparam int PAT_NEIGHBOUR = 2;

    // Payload layout: sequence number, injection timestamp, source coordinates
    localparam int SEQ_LSB = 0;
    localparam int TS_LSB  = 32;
    localparam int SRC_LSB = 64;

    // 16-bit Fibonacci LFSR, taps 16,14,13,11 (bit indices 15,13,12,10)
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/token_bucket.sv
`default_nettype none
// ============================================================================
//  Module      : token_bucket
//  Description : Rate regulator. One token is added every RATE cycles, the
//                bucket holds at most SIGMA tokens and starts full after reset.
//                A consume removes one token; consume and refill in the same
//                cycle cancel out.
//  Ports       : clk, rst             - clock, synchronous active-high reset
//                i_consume            - take one token this cycle
//                o_token_available    - at least one token is held
//  Revision    : 1.0 - initial release
// ============================================================================
module token_bucket #(
    parameter int RATE  = 20,
    parameter int SIGMA = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic i_consume,
    output logic o_token_available
);

    localparam int TIM_W = (RATE > 1) ? $clog2(RATE) : 1;
    localparam int TOK_W = $clog2(SIGMA + 1);

    logic [TIM_W-1:0] r_timer_q, w_timer_d;
    logic [TOK_W-1:0] r_tokens_q, w_tokens_d;
    logic             w_refill;

    assign w_refill = (r_timer_q == TIM_W'(RATE - 1));

    always_comb begin
        w_timer_d  = w_refill ? '0 : r_timer_q + TIM_W'(1);
        w_tokens_d = r_tokens_q;
        if (i_consume && (r_tokens_q != '0)) begin
            w_tokens_d = w_tokens_d - TOK_W'(1);
        end
        // refill is applied after consume so a full bucket stays full
        if (w_refill && (w_tokens_d != TOK_W'(SIGMA))) begin
            w_tokens_d = w_tokens_d + TOK_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer_q  <= '0;
            r_tokens_q <= TOK_W'(SIGMA);
        end else begin
            r_timer_q  <= w_timer_d;
            r_tokens_q <= w_tokens_d;
        end
    end

    assign o_token_available = (r_tokens_q != '0);

endmodule
`default_nettype wire

// File: rtl/traffic_client.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_client
//  Description : NoC endpoint traffic generator / sink. Injects N_PACKETS
//                rate-regulated packets, destination from PATTERN, VCs used
//                round-robin. Sinks every ejected packet, flags misroutes and
//                accumulates end-to-end latency.
//  Ports       : clk, rst                  - clock, sync active-high reset
//                i_ack                     - router took current injection
//                i_v/i_vc/i_x/i_y/i_data   - injection request (registered)
//                o_v/o_x/o_y/o_data        - ejection input, always accepted
//                done                      - all packets injected and acked
//                rx_count/lat_sum/err      - receive statistics
//  Revision    : 1.0 - initial release
// ============================================================================
module traffic_client
    import noc_client_pkg::*;
#(
    parameter int          X_W       = 2,
    parameter int          Y_W       = 2,
    parameter int          X         = 0,
    parameter int          Y         = 0,
    parameter int          VC_W      = 2,
    parameter int          D_W       = 256,
    parameter int          N_PACKETS = 128,
    parameter int          RATE      = 20,
    parameter int          SIGMA     = 3,
    parameter int          PATTERN   = 0,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_ack,
    output logic            i_v,
    output logic [VC_W-1:0] i_vc,
    output logic [X_W-1:0]  i_x,
    output logic [Y_W-1:0]  i_y,
    output logic [D_W-1:0]  i_data,
    input  logic            o_v,
    input  logic [X_W-1:0]  o_x,
    input  logic [Y_W-1:0]  o_y,
    input  logic [D_W-1:0]  o_data,
    output logic            done,
    output logic [31:0]     rx_count,
    output logic [47:0]     lat_sum,
    output logic            err
);

    localparam int             X_MAX   = 1 << X_W;
    localparam int             Y_MAX   = 1 << Y_W;
    localparam int             SRC_END = SRC_LSB + X_W + Y_W;
    localparam logic [X_W-1:0] C_SELF_X = X_W'(X % X_MAX);
    localparam logic [Y_W-1:0] C_SELF_Y = Y_W'(Y % Y_MAX);

    // ---------------- state ----------------
    logic            r_iv_q,       w_iv_d;
    logic [VC_W-1:0] r_vc_q,       w_vc_d;
    logic [X_W-1:0]  r_x_q,        w_x_d;
    logic [Y_W-1:0]  r_y_q,        w_y_d;
    logic [D_W-1:0]  r_data_q,     w_data_d;
    logic [VC_W-1:0] r_vc_ptr_q,   w_vc_ptr_d;
    logic [31:0]     r_tx_count_q, w_tx_count_d;
    logic [31:0]     r_cyc_q;
    logic [15:0]     r_lfsr_q,     w_lfsr_d;
    logic            r_done_q,     w_done_d;
    logic [31:0]     r_rx_count_q, w_rx_count_d;
    logic [47:0]     r_lat_sum_q,  w_lat_sum_d;
    logic            r_err_q,      w_err_d;

    logic            w_token_available;
    logic            w_consume;
    logic [X_W-1:0]  w_raw_x, w_dst_x;
    logic [Y_W-1:0]  w_raw_y;
    logic [D_W-1:0]  w_payload;
    logic [31:0]     w_latency;
    logic            w_src_is_self;
    logic            w_bad_dst;

    token_bucket #(
        .RATE  (RATE),
        .SIGMA (SIGMA)
    ) regulator (
        .clk               (clk),
        .rst               (rst),
        .i_consume         (w_consume),
        .o_token_available (w_token_available)
    );

    // i_v doubles as the "pending" flag: a request is outstanding until acked
    assign w_consume = w_token_available & (~r_iv_q | i_ack)
                     & (r_tx_count_q < 32'(N_PACKETS));

    // ---------------- destination selection ----------------
    always_comb begin
        w_raw_x = r_lfsr_q[X_W-1:0];
        w_raw_y = r_lfsr_q[X_W+Y_W-1:X_W];
        if (PATTERN == PAT_TRANSPOSE) begin
            w_raw_x = X_W'(Y % X_MAX);
            w_raw_y = Y_W'(X % Y_MAX);
        end else if (PATTERN == PAT_NEIGHBOUR) begin
            w_raw_x = X_W'((X + 1) % X_MAX);
            w_raw_y = C_SELF_Y;
        end
        // never address ourselves: step one column east (wraps)
        w_dst_x = w_raw_x;
        if ((w_raw_x == C_SELF_X) && (w_raw_y == C_SELF_Y)) begin
            w_dst_x = w_raw_x + X_W'(1);
        end
    end

    always_comb begin
        w_payload                     = '0;
        w_payload[SEQ_LSB +: 32]      = r_tx_count_q;
        w_payload[TS_LSB +: 32]       = r_cyc_q;
        w_payload[SRC_LSB +: X_W]     = C_SELF_X;
        w_payload[SRC_LSB+X_W +: Y_W] = C_SELF_Y;
    end

    // ---------------- receive-side decode ----------------
    assign w_latency     = r_cyc_q - o_data[TS_LSB +: 32];
    assign w_src_is_self = (o_data[SRC_LSB +: X_W] == C_SELF_X)
                         && (o_data[SRC_LSB+X_W +: Y_W] == C_SELF_Y);
    assign w_bad_dst     = (o_x != C_SELF_X) || (o_y != C_SELF_Y);

    // ---------------- next state ----------------
    always_comb begin
        w_iv_d       = r_iv_q;
        w_vc_d       = r_vc_q;
        w_x_d        = r_x_q;
        w_y_d        = r_y_q;
        w_data_d     = r_data_q;
        w_vc_ptr_d   = r_vc_ptr_q;
        w_tx_count_d = r_tx_count_q;
        w_lfsr_d     = r_lfsr_q;
        w_rx_count_d = r_rx_count_q;
        w_lat_sum_d  = r_lat_sum_q;
        w_err_d      = r_err_q;

        // the ack that completes the last packet arrives while tx_count
        // already equals N_PACKETS
        w_done_d = r_done_q | (N_PACKETS == 0)
                 | (r_iv_q & i_ack & (r_tx_count_q == 32'(N_PACKETS)));

        if (w_consume) begin
            w_iv_d       = 1'b1;
            w_vc_d       = r_vc_ptr_q;
            w_x_d        = w_dst_x;
            w_y_d        = w_raw_y;
            w_data_d     = w_payload;
            w_vc_ptr_d   = r_vc_ptr_q + VC_W'(1);
            w_tx_count_d = r_tx_count_q + 32'd1;
            w_lfsr_d     = lfsr_next(r_lfsr_q);
        end else if (r_iv_q && i_ack) begin
            w_iv_d = 1'b0;
        end

        if (o_v) begin
            if (r_rx_count_q != '1) begin
                w_rx_count_d = r_rx_count_q + 32'd1;
            end
            w_lat_sum_d = r_lat_sum_q + {16'd0, w_latency};
            if (w_bad_dst || w_src_is_self) begin
                w_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_iv_q       <= 1'b0;
            r_vc_q       <= '0;
            r_x_q        <= '0;
            r_y_q        <= '0;
            r_data_q     <= '0;
            r_vc_ptr_q   <= '0;
            r_tx_count_q <= '0;
            r_cyc_q      <= '0;
            r_lfsr_q     <= SEED;
            r_done_q     <= 1'b0;
            r_rx_count_q <= '0;
            r_lat_sum_q  <= '0;
            r_err_q      <= 1'b0;
        end else begin
            r_iv_q       <= w_iv_d;
            r_vc_q       <= w_vc_d;
            r_x_q        <= w_x_d;
            r_y_q        <= w_y_d;
            r_data_q     <= w_data_d;
            r_vc_ptr_q   <= w_vc_ptr_d;
            r_tx_count_q <= w_tx_count_d;
            r_cyc_q      <= r_cyc_q + 32'd1;
            r_lfsr_q     <= w_lfsr_d;
            r_done_q     <= w_done_d;
            r_rx_count_q <= w_rx_count_d;
            r_lat_sum_q  <= w_lat_sum_d;
            r_err_q      <= w_err_d;
        end
    end

    // sequence number and spare payload bits are not inspected on receive
    logic w_unused_seq;
    assign w_unused_seq = ^o_data[SEQ_LSB +: 32];

    generate
        if (D_W > SRC_END) begin : g_spare_bits
            logic w_unused_hi;
            assign w_unused_hi = ^o_data[D_W-1:SRC_END];
        end
    endgenerate

    assign i_v      = r_iv_q;
    assign i_vc     = r_vc_q;
    assign i_x      = r_x_q;
    assign i_y      = r_y_q;
    assign i_data   = r_data_q;
    assign done     = r_done_q;
    assign rx_count = r_rx_count_q;
    assign lat_sum  = r_lat_sum_q;
    assign err      = r_err_q;

endmodule
`default_nettype wire

// File: doc/traffic_client.md
Name: traffic_client

Overview:
Parametrised successor to the torus NoC endpoint client. It generates a rate-regulated stream of N_PACKETS to destinations chosen by a selectable traffic pattern, and spreads packets round-robin over all virtual channels. On the receive side it sinks every delivered packet, checks that the packet was routed to this node, and accumulates end-to-end latency. One instance sits at each router's local port; the bench reads its done/stat outputs.

Parameters:
X_W, 2, x-coordinate width; X_MAX = 1<<X_W
Y_W, 2, y-coordinate width; Y_MAX = 1<<Y_W
X, 0, this node's x coordinate
Y, 0, this node's y coordinate
VC_W, 2, VC index width; N_VC = 1<<VC_W
D_W, 256, flit data width; must be >= 64+X_W+Y_W
N_PACKETS, 128, packets to inject
RATE, 20, token_bucket refill rate
SIGMA, 3, token_bucket burst depth
PATTERN, 0, 0=uniform random, 1=transpose, 2=x-neighbour
SEED, 16'hACE1, LFSR seed; must be nonzero

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
i_ack  in  1  router accepted current injection
i_v  out  1  injection valid
i_vc  out  VC_W  injection VC
i_x  out  X_W  destination x
i_y  out  Y_W  destination y
i_data  out  D_W  injection payload
o_v  in  1  ejection valid; always accepted
o_x  in  X_W  ejected packet destination x
o_y  in  Y_W  ejected packet destination y
o_data  in  D_W  ejected payload
done  out  1  all packets injected and acked
rx_count  out  32  packets received
lat_sum  out  48  summed latency of received packets
err  out  1  sticky misroute / bad-payload flag

Behaviour:
- Reset: all outputs, counters, cycle timer, and VC pointer go to 0; the LFSR loads SEED. Reset asserted mid-operation aborts any pending injection; i_v is 0 on the next cycle.
- cyc: free-running 32-bit counter, +1 every cycle, wraps mod 2^32.
- Injection uses a token_bucket sub-module (RATE, SIGMA).
- consume = token_available & (!pending | i_ack) & (tx_count < N_PACKETS).
- On consume, the following are registered and take effect next cycle:
  - i_v=1, pending=1, tx_count+1
  - i_vc = vc_ptr; vc_ptr advances mod N_VC
  - i_data[31:0] = tx_count (sequence number)
  - i_data[63:32] = cyc
  - next X_W bits = X, next Y_W bits = Y; remaining bits 0
- While i_v=1 and i_ack=0, every i_* output holds stable.
- If i_ack=1 and there is no consume in the same cycle: i_v and pending clear next cycle.
- i_ack and consume in the same cycle: back-to-back injection, i_v stays 1 with new fields.
- Destination selection:
  - PATTERN 0: x,y = LFSR[X_W-1:0], LFSR[X_W+Y_W-1:X_W]. 16-bit Fibonacci LFSR, taps 16,14,13,11, advances only on consume.
  - PATTERN 1: (x,y) = (Y mod X_MAX, X mod Y_MAX).
  - PATTERN 2: ((X+1) mod X_MAX, Y).
  - Self-avoid for every pattern: if the result equals (X,Y), use x = (x+1) mod X_MAX.
- done: set the cycle after the i_ack that completes packet N_PACKETS. It is sticky until rst. With N_PACKETS=0, done rises one cycle after reset deasserts.
- Receive, on each cycle with o_v=1:
  - rx_count+1
  - lat_sum += zero-extend(cyc - o_data[63:32]), 32-bit modular subtraction
  - err set if (o_x,o_y) != (X,Y) or source field == (X,Y)
  - rx_count saturates at 2^32-1; lat_sum wraps.
- Simultaneous injection and ejection are independent. Outputs are registered with no combinational path from inputs.

Decomposition:
- Package noc_client_pkg holds:
  - PATTERN encodings as localparams (PAT_UNIFORM, PAT_TRANSPOSE, PAT_NEIGHBOUR)
  - payload field offsets (SEQ_LSB=0, TS_LSB=32, SRC_LSB=64)
  - the LFSR tap constant
- Sub-module: the existing token_bucket, instantiated as regulator. The LFSR stays inline.

Test Plan:
- PATTERN=2, X=1,Y=0, N_PACKETS=4, i_ack tied 1 -> 4 injections to (2,0), i_vc 0,1,2,3; done=1 one cycle after the 4th ack.
- i_ack held 0 for 10 cycles after the first i_v -> all i_* stable for 10 cycles; tx_count stays 1.
- PATTERN=1 at X=2,Y=2 -> self-avoid gives (3,2). At X=1,Y=3 -> destination (3,1).
- o_v pulse with o_x/o_y=(X,Y), o_data[63:32]=cyc-7 -> rx_count=1, lat_sum=7, err=0. Repeat with o_x wrong -> err=1, sticky.
- Timestamp wrap: cyc=0x00000002, received timestamp 0xFFFFFFFE -> lat_sum increments by 4.
- rst asserted while i_v=1, i_ack=0 -> i_v=0, done=0, all counters 0 next cycle; the first post-reset destination under PATTERN 0 matches the SEED-derived value.
